// File: rtl/seq_scan_arb.sv
// Two-requester round-robin front end feeding an overlapping Moore 1101 scanner.
// Each granted word is scanned MSB-first and its hit count is returned with the winner's id.
module seq_scan_arb #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [W-1:0]  req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [W-1:0]  req1_data,
    output logic          req1_ready,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_id,
    output logic [CW-1:0] res_count,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} ctl_e;
    typedef enum logic [2:0] {ST_A, ST_B, ST_C, ST_D, ST_E} det_e;

    localparam int KW = $clog2(W);
    localparam logic [KW-1:0] LAST = KW'(W - 1);
    localparam logic [CW-1:0] CMAX = '1;

    ctl_e          state_q;
    det_e          det_q;
    det_e          det_d;
    logic [KW-1:0] cnt_q;
    logic [CW-1:0] hits_q;
    logic [W-1:0]  word_q;
    logic          id_q;
    logic          rr_q;
    logic          gnt0;
    logic          gnt1;

    function automatic det_e det_next(input det_e s, input logic x);
        case (s)
            ST_A:    det_next = x ? ST_B : ST_A;
            ST_B:    det_next = x ? ST_C : ST_A;
            ST_C:    det_next = x ? ST_C : ST_D;
            ST_D:    det_next = x ? ST_E : ST_A;
            ST_E:    det_next = x ? ST_C : ST_A;
            default: det_next = ST_A;
        endcase
    endfunction

    // The word register shifts left, so its MSB is always the next bit to scan.
    always_comb begin
        det_d = det_next(det_q, word_q[W-1]);
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE && !rst) begin
            gnt0 = req0_valid && (!req1_valid || !rr_q);
            gnt1 = req1_valid && (!req0_valid || rr_q);
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign res_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign res_id     = id_q;
    assign res_count  = hits_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            det_q   <= ST_A;
            cnt_q   <= '0;
            hits_q  <= '0;
            word_q  <= '0;
            id_q    <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        word_q  <= gnt1 ? req1_data : req0_data;
                        id_q    <= gnt1;
                        rr_q    <= !gnt1;
                        det_q   <= ST_A;
                        hits_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    det_q  <= det_d;
                    word_q <= word_q << 1;
                    cnt_q  <= cnt_q + KW'(1);
                    if (det_d == ST_E && hits_q != CMAX) begin
                        hits_q <= hits_q + CW'(1);
                    end
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_arb.sv
// Bench for seq_scan_arb: directed and random words against a sliding-window 1101 counter.
module tb_seq_scan_arb;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [W-1:0]  req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          res_valid, res_ready, res_id, busy;
    logic [CW-1:0] res_count;

    logic          s_req0_valid, s_req1_valid;
    logic [15:0]   s_req0_data, s_req1_data;
    logic          s_req0_ready, s_req1_ready;
    logic          s_res_valid, s_res_ready, s_res_id, s_busy;
    logic [0:0]    s_res_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_scan_arb #(.W(W), .CW(CW)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_count(res_count), .busy(busy)
    );

    seq_scan_arb #(.W(16), .CW(1)) u_sat (
        .clk(clk), .rst(rst),
        .req0_valid(s_req0_valid), .req0_data(s_req0_data), .req0_ready(s_req0_ready),
        .req1_valid(s_req1_valid), .req1_data(s_req1_data), .req1_ready(s_req1_ready),
        .res_valid(s_res_valid), .res_ready(s_res_ready), .res_id(s_res_id),
        .res_count(s_res_count), .busy(s_busy)
    );

    // Reference: count every 4-bit window equal to 1101, then clamp to the count range.
    function automatic int model_count(input logic [31:0] w, input int width, input int cw);
        int n = 0;
        for (int i = 0; i + 4 <= width; i++) begin
            if (((w >> (width - 4 - i)) & 32'hF) == 32'hD) n++;
        end
        if (n > (1 << cw) - 1) n = (1 << cw) - 1;
        return n;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic xfer(input bit id, input logic [W-1:0] d, input bit hold,
                        output int wt, output int lat, output bit rid,
                        output logic [CW-1:0] rc);
        wt = 0; lat = 0; rid = 0; rc = '0;
        @(negedge clk);
        res_ready = !hold;
        if (id) begin req1_valid = 1'b1; req1_data = d; end
        else    begin req0_valid = 1'b1; req0_data = d; end
        #1;
        while (!(id ? req1_ready : req0_ready) && wt < 40) begin
            @(negedge clk); #1; wt++;
        end
        if (wt >= 40) begin
            total++; bad++;
            $display("FAIL xfer_grant_timeout got=none exp=ready");
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 1;
        #1;
        while (!res_valid && lat < 40) begin
            @(negedge clk); #1; lat++;
        end
        rid = res_id;
        rc  = res_count;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_data = 8'hFF; req1_data = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({res_valid, res_id, res_count, req0_ready, req1_ready, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {res_valid, res_id, res_count, req0_ready, req1_ready, busy});
        end
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] words [4] = '{8'b11011010, 8'b00001101, 8'b11111111, 8'b01101101};
        bit ids [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        int wt, lat;
        bit rid;
        logic [CW-1:0] rc;
        for (int i = 0; i < 4; i++) begin
            xfer(ids[i], words[i], 1'b0, wt, lat, rid, rc);
            total++;
            if (lat !== W + 1) begin
                bad++; $display("FAIL basic_latency[%0d] got=%0d exp=%0d", i, lat, W + 1);
            end
            total++;
            if (rid !== ids[i]) begin
                bad++; $display("FAIL basic_id[%0d] got=%0d exp=%0d", i, rid, ids[i]);
            end
            total++;
            if (rc !== CW'(model_count(32'(words[i]), W, CW))) begin
                bad++;
                $display("FAIL basic_count[%0d] got=%0d exp=%0d", i, rc,
                         model_count(32'(words[i]), W, CW));
            end
        end
    endtask

    task automatic test_random();
        int wt, lat;
        bit rid, id;
        logic [CW-1:0] rc;
        logic [W-1:0] d;
        for (int i = 0; i < 10; i++) begin
            id = 1'($urandom_range(0, 1));
            d  = W'($urandom);
            xfer(id, d, 1'b0, wt, lat, rid, rc);
            total++;
            if ({rid, rc} !== {id, CW'(model_count(32'(d), W, CW))} || lat !== W + 1) begin
                bad++;
                $display("FAIL random[%0d] got=id%0d/cnt%0d/lat%0d exp=id%0d/cnt%0d/lat%0d",
                         i, rid, rc, lat, id, model_count(32'(d), W, CW), W + 1);
            end
        end
    endtask

    task automatic test_only_req1();
        int wt, lat;
        bit rid;
        logic [CW-1:0] rc;
        pulse_reset();
        xfer(1'b1, 8'b10110100, 1'b0, wt, lat, rid, rc);
        total++;
        if (wt !== 0) begin
            bad++; $display("FAIL only_req1_wait got=%0d exp=0", wt);
        end
        total++;
        if (rid !== 1'b1) begin
            bad++; $display("FAIL only_req1_id got=%0d exp=1", rid);
        end
        total++;
        if (rc !== CW'(model_count(32'h000000B4, W, CW))) begin
            bad++; $display("FAIL only_req1_count got=%0d exp=%0d", rc,
                            model_count(32'h000000B4, W, CW));
        end
    endtask

    task automatic test_round_robin();
        logic [CW:0] exp_q[$];
        logic [CW:0] obs_q[$];
        bit exp_g = 1'b0;
        int n;
        pulse_reset();
        @(negedge clk);
        res_ready  = 1'b1;
        req0_data  = W'($urandom);
        req1_data  = W'($urandom);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!(req0_ready || req1_ready) && n < 40) begin
                if (res_valid) obs_q.push_back({res_id, res_count});
                @(negedge clk); #1; n++;
            end
            total++;
            if ({req1_ready, req0_ready} !== (exp_g ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL rr_grant[%0d] got=%b exp=%b", g, {req1_ready, req0_ready},
                         exp_g ? 2'b10 : 2'b01);
            end
            exp_q.push_back({exp_g, CW'(model_count(32'(exp_g ? req1_data : req0_data), W, CW))});
            @(negedge clk);
            if (exp_g) req1_data = W'($urandom);
            else       req0_data = W'($urandom);
            if (g == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            exp_g = !exp_g;
            #1;
        end
        n = 0;
        while (!res_valid && n < 40) begin
            @(negedge clk); #1; n++;
        end
        if (res_valid) obs_q.push_back({res_id, res_count});
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL rr_result_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL rr_result[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int wt, lat;
        bit rid;
        logic [CW-1:0] rc;
        logic [W-1:0] d = 8'b11010110;
        logic [CW+4:0] expv;
        expv = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CW'(model_count(32'(d), W, CW))};
        xfer(1'b0, d, 1'b1, wt, lat, rid, rc);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            total++;
            if ({res_valid, busy, req0_ready, req1_ready, res_id, res_count} !== expv) begin
                bad++;
                $display("FAIL backpressure_hold[%0d] got=%b exp=%b", i,
                         {res_valid, busy, req0_ready, req1_ready, res_id, res_count}, expv);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        @(negedge clk); #1;
        total++;
        if ({res_valid, busy} !== 2'b00) begin
            bad++; $display("FAIL backpressure_release got=%b exp=00", {res_valid, busy});
        end
    endtask

    task automatic test_reset_mid_shift();
        int wt, lat, n;
        bit rid, seen;
        logic [CW-1:0] rc;
        logic [W-1:0] d;
        @(negedge clk);
        res_ready  = 1'b1;
        req1_data  = 8'b11011101;
        req1_valid = 1'b1;
        #1;
        n = 0;
        while (!req1_ready && n < 40) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({res_valid, res_id, res_count, req0_ready, req1_ready, busy} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs got=%b exp=0",
                     {res_valid, res_id, res_count, req0_ready, req1_ready, busy});
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL reset_mid_no_result got=%0d exp=0", seen);
        end
        d = W'($urandom);
        xfer(1'b0, d, 1'b0, wt, lat, rid, rc);
        total++;
        if ({rid, rc} !== {1'b0, CW'(model_count(32'(d), W, CW))} || lat !== W + 1) begin
            bad++;
            $display("FAIL reset_mid_next got=id%0d/cnt%0d/lat%0d exp=id0/cnt%0d/lat%0d",
                     rid, rc, lat, model_count(32'(d), W, CW), W + 1);
        end
    endtask

    task automatic test_saturation();
        int n;
        int lat;
        @(negedge clk);
        s_req0_data  = 16'b1101101101101101;
        s_req0_valid = 1'b1;
        #1;
        n = 0;
        while (!s_req0_ready && n < 40) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        s_req0_valid = 1'b0;
        lat = 1;
        #1;
        while (!s_res_valid && lat < 60) begin
            @(negedge clk); #1; lat++;
        end
        total++;
        if (lat !== 17) begin
            bad++; $display("FAIL sat_latency got=%0d exp=17", lat);
        end
        total++;
        if ({s_res_id, s_res_count} !== {1'b0, 1'(model_count(32'hDB6D, 16, 1))}) begin
            bad++;
            $display("FAIL sat_count got=id%0d/cnt%0d exp=id0/cnt%0d", s_res_id, s_res_count,
                     model_count(32'hDB6D, 16, 1));
        end
    endtask

    initial begin
        s_req0_valid = 1'b0; s_req1_valid = 1'b0;
        s_req0_data  = '0;   s_req1_data  = '0;
        s_res_ready  = 1'b1;
        test_reset();
        test_basic();
        test_only_req1();
        test_round_robin();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
